// File: rtl/vga_sync_decoder.sv
// Recovers column/row/disp_ena from a VGA sync stream (1-clock latency), verifies line/frame geometry with a
// lock FSM and captures a probe pixel. Defining VGA_DECODE_CRC_EN adds a per-frame CRC-16 of the visible pixels.
module vga_sync_decoder #(
  parameter int   H_START  = 144,
  parameter int   H_ACTIVE = 640,
  parameter int   H_TOTAL  = 800,
  parameter int   V_START  = 35,
  parameter int   V_ACTIVE = 480,
  parameter int   V_TOTAL  = 525,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [3:0]  r_in,
  input  logic [3:0]  g_in,
  input  logic [3:0]  b_in,
  input  logic [9:0]  probe_col,
  input  logic [9:0]  probe_row,
  output logic [9:0]  column,
  output logic [9:0]  row,
  output logic        disp_ena,
  output logic [11:0] rgb_out,
  output logic        locked,
  output logic        sync_err,
  output logic [11:0] line_len,
  output logic [10:0] frame_lines,
  output logic [11:0] probe_rgb,
  output logic        probe_valid,
  output logic [15:0] frame_crc
);

  typedef enum logic [1:0] {UNLOCKED, MEASURE, LOCKED} lock_state_t;

  localparam logic [11:0] H_START_C = 12'(H_START);
  localparam logic [11:0] H_END_C   = 12'(H_START + H_ACTIVE);
  localparam logic [11:0] H_TOTAL_C = 12'(H_TOTAL);
  localparam logic [11:0] H_TMO_C   = 12'(2 * H_TOTAL);
  localparam logic [10:0] V_START_C = 11'(V_START);
  localparam logic [10:0] V_END_C   = 11'(V_START + V_ACTIVE);
  localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);

  lock_state_t state;
  logic        hs_q, vs_q, skip_q, bad_q, probe_done;
  logic [11:0] hcnt_q;
  logic [10:0] vcnt_q;

  logic        hs_le, vs_le, timeout, len_bad, frame_bad, active, ena;
  logic [11:0] hcnt_inc, hcnt_cur, rgb_cur;
  logic [10:0] vcnt_cur, frame_cnt;
  logic [9:0]  col_cur, row_cur;

  // Counts describe the sample currently on the inputs; registering them gives the 1-clock latency.
  always_comb begin
    hs_le     = (h_sync == H_POL) && (hs_q != H_POL);
    vs_le     = (v_sync == V_POL) && (vs_q != V_POL);
    hcnt_inc  = (hcnt_q == 12'hFFF) ? 12'hFFF : hcnt_q + 12'd1;
    hcnt_cur  = hs_le ? 12'd0 : hcnt_inc;
    frame_cnt = vcnt_q + {10'd0, hs_le};
    if (vs_le)
      vcnt_cur = 11'd0;
    else if (hs_le && vcnt_q != 11'h7FF)
      vcnt_cur = vcnt_q + 11'd1;
    else
      vcnt_cur = vcnt_q;
    timeout   = (hcnt_cur == H_TMO_C);
    len_bad   = hs_le && !skip_q && (hcnt_inc != H_TOTAL_C);
    frame_bad = (frame_cnt != V_TOTAL_C);
    active    = (hcnt_cur >= H_START_C) && (hcnt_cur < H_END_C) &&
                (vcnt_cur >= V_START_C) && (vcnt_cur < V_END_C);
    ena       = active && locked;
    col_cur   = active ? 10'(hcnt_cur - H_START_C) : 10'd0;
    row_cur   = active ? 10'(vcnt_cur - V_START_C) : 10'd0;
    rgb_cur   = ena ? {r_in, g_in, b_in} : 12'd0;
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q        <= H_POL;
      vs_q        <= V_POL;
      hcnt_q      <= 12'd0;
      vcnt_q      <= 11'd0;
      column      <= 10'd0;
      row         <= 10'd0;
      disp_ena    <= 1'b0;
      rgb_out     <= 12'd0;
      line_len    <= 12'd0;
      frame_lines <= 11'd0;
      probe_rgb   <= 12'd0;
      probe_valid <= 1'b0;
      probe_done  <= 1'b0;
    end else begin
      hs_q        <= h_sync;
      vs_q        <= v_sync;
      hcnt_q      <= hcnt_cur;
      vcnt_q      <= vcnt_cur;
      column      <= col_cur;
      row         <= row_cur;
      disp_ena    <= ena;
      rgb_out     <= rgb_cur;
      probe_valid <= 1'b0;
      if (hs_le)
        line_len <= hcnt_inc;
      if (vs_le) begin
        frame_lines <= frame_cnt;
        probe_done  <= 1'b0;
      end else if (ena && !probe_done && col_cur == probe_col && row_cur == probe_row) begin
        probe_rgb   <= rgb_cur;
        probe_valid <= 1'b1;
        probe_done  <= 1'b1;
      end
    end
  end

  // skip_q masks the first line after reset/timeout, whose start point is unknown.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= UNLOCKED;
      bad_q    <= 1'b0;
      skip_q   <= 1'b1;
      locked   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      if (timeout)
        skip_q <= 1'b1;
      else if (hs_le)
        skip_q <= 1'b0;
      case (state)
        UNLOCKED: begin
          if (vs_le) begin
            state <= MEASURE;
            bad_q <= 1'b0;
          end
        end
        MEASURE: begin
          if (vs_le) begin
            if (!bad_q && !len_bad && !frame_bad) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
            bad_q <= 1'b0;
          end else if (len_bad || timeout) begin
            bad_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (len_bad || timeout || (vs_le && frame_bad)) begin
            state    <= UNLOCKED;
            locked   <= 1'b0;
            sync_err <= 1'b1;
          end
        end
        default: begin
          state  <= UNLOCKED;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_DECODE_CRC_EN
  logic [15:0] crc_q;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] x;
    x = c;
    for (int i = 11; i >= 0; i--)
      x = {x[14:0], 1'b0} ^ ((x[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return x;
  endfunction

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q     <= 16'hFFFF;
      frame_crc <= 16'h0000;
    end else if (vs_le) begin
      if (locked)
        frame_crc <= crc_q;
      crc_q <= 16'hFFFF;
    end else if (ena) begin
      crc_q <= crc_step(crc_q, rgb_cur);
    end
  end
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced 40x20 geometry with random pixel colours; positions, lock
// transitions, probe capture and frame CRC are predicted from the stream's (x, y) raster coordinates.
module tb_vga_sync_decoder;
  localparam int HS = 8, HA = 24, HT = 40, HSW = 4;
  localparam int VS = 4, VA = 12, VT = 20, VSW = 2;

  logic        pixel_clk = 1'b0;
  logic        reset_n;
  logic        h_sync, v_sync;
  logic [3:0]  r_in, g_in, b_in;
  logic [9:0]  probe_col, probe_row;
  logic [9:0]  column, row;
  logic        disp_ena, locked, sync_err, probe_valid;
  logic [11:0] rgb_out, line_len, probe_rgb;
  logic [10:0] frame_lines;
  logic [15:0] frame_crc;

  int checks = 0;
  int failures = 0;
  int err_cycles = 0;
  int pv_cycles = 0;
  int pcol, prow;
  bit exp_lock;
  logic        lock_x0, err_x0, lock_v0;
  logic [11:0] len_x0;
  logic [10:0] flines_v0;
  logic [15:0] crc_v0, crc_want;
  logic [15:0] mcrc = 16'hFFFF;
  logic [15:0] mcrc_done = 16'hFFFF;

  vga_sync_decoder #(
    .H_START(HS), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_START(VS), .V_ACTIVE(VA), .V_TOTAL(VT),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .h_sync(h_sync), .v_sync(v_sync),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .probe_col(probe_col), .probe_row(probe_row),
    .column(column), .row(row), .disp_ena(disp_ena), .rgb_out(rgb_out), .locked(locked),
    .sync_err(sync_err), .line_len(line_len), .frame_lines(frame_lines),
    .probe_rgb(probe_rgb), .probe_valid(probe_valid), .frame_crc(frame_crc)
  );

  always #5 pixel_clk = ~pixel_clk;

  always @(negedge pixel_clk) begin
    if (sync_err === 1'b1) err_cycles <= err_cycles + 1;
    if (probe_valid === 1'b1) pv_cycles <= pv_cycles + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // CRC-16-CCITT reference, one 12-bit word MSB first.
  function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Drives one raster line (samples xs..len-1); x=0 is the h_sync leading edge, y=0 carries the v_sync edge.
  task automatic line(input int y, input int xs, input int len, input bit hs_on, input bit chk_on);
    for (int x = xs; x < len; x++) begin
      logic [11:0] c;
      bit act, on;
      c = 12'($urandom);
      if (x == HS && y == VS) c = 12'hF00;
      if (x == HS + pcol && y == VS + prow) c = 12'hFFF;
      h_sync = (hs_on && x < HSW) ? 1'b0 : 1'b1;
      v_sync = (y < VSW) ? 1'b0 : 1'b1;
      {r_in, g_in, b_in} = c;
      @(negedge pixel_clk);
      act = (x >= HS) && (x < HS + HA) && (y >= VS) && (y < VS + VA);
      on  = act && exp_lock;
      if (x == 0 && y == 0) begin
        lock_v0   = locked;
        flines_v0 = frame_lines;
        crc_v0    = frame_crc;
        mcrc_done = mcrc;
        mcrc      = 16'hFFFF;
      end
      if (x == 0) begin
        err_x0  = sync_err;
        lock_x0 = locked;
        len_x0  = line_len;
      end
      if (chk_on) begin
        chk("column", 32'(column), 32'(act ? x - HS : 0));
        chk("row", 32'(row), 32'(act ? y - VS : 0));
        chk("disp_ena", 32'(disp_ena), 32'(on));
        chk("rgb_out", 32'(rgb_out), on ? 32'(c) : 32'd0);
        chk("probe_valid", 32'(probe_valid), 32'(on && x == HS + pcol && y == VS + prow));
        if (on) mcrc = crc12(mcrc, c);
      end
    end
  endtask

  task automatic frame(input bit chk_on);
    for (int y = 0; y < VT; y++) line(y, 0, HT, 1'b1, chk_on);
  endtask

  task automatic check_crc(input string tag);
    crc_want = mcrc_done;
`ifndef VGA_DECODE_CRC_EN
    crc_want = 16'h0000;
`endif
    chk(tag, 32'(crc_v0), 32'(crc_want));
  endtask

  initial begin
    reset_n = 1'b0;
    h_sync = 1'b1; v_sync = 1'b1;
    {r_in, g_in, b_in} = 12'h000;
    pcol = $urandom_range(HA - 1, 0);
    prow = $urandom_range(VA - 1, 0);
    probe_col = 10'(pcol);
    probe_row = 10'(prow);
    exp_lock = 1'b0;
    repeat (3) @(negedge pixel_clk);
    chk("rst_column", 32'(column), 0);
    chk("rst_row", 32'(row), 0);
    chk("rst_disp_ena", 32'(disp_ena), 0);
    chk("rst_rgb_out", 32'(rgb_out), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_sync_err", 32'(sync_err), 0);
    chk("rst_line_len", 32'(line_len), 0);
    chk("rst_frame_lines", 32'(frame_lines), 0);
    chk("rst_probe_rgb", 32'(probe_rgb), 0);
    chk("rst_probe_valid", 32'(probe_valid), 0);
    chk("rst_frame_crc", 32'(frame_crc), 0);
    reset_n = 1'b1;

    // Acquisition: first vs_le opens measurement, second closes a clean frame.
    line(VT - 1, HSW, HT, 1'b1, 1'b0);
    frame(1'b0);
    chk("locked_before_2nd_vsle", 32'(locked), 0);
    exp_lock = 1'b1;
    frame(1'b1);
    chk("lock_rise_at_2nd_vsle", 32'(lock_v0), 1);
    chk("frame_lines", 32'(flines_v0), VT);
    chk("line_len", 32'(line_len), HT);
    chk("probe_pulses_one_frame", 32'(pv_cycles), 1);
    chk("probe_rgb", 32'(probe_rgb), 32'h0000_0FFF);

    frame(1'b1);
    chk("still_locked", 32'(lock_v0), 1);
    chk("frame_lines_c", 32'(flines_v0), VT);
    check_crc("frame_crc_b");
    chk("no_sync_err_yet", 32'(err_cycles), 0);

    // One short line while locked.
    for (int y = 0; y < 8; y++) line(y, 0, (y == 7) ? HT - 1 : HT, 1'b1, 1'b0);
    check_crc("frame_crc_c");
    line(8, 0, HT, 1'b1, 1'b0);
    chk("short_sync_err", 32'(err_x0), 1);
    chk("short_unlock", 32'(lock_x0), 0);
    chk("short_line_len", 32'(len_x0), HT - 1);
    for (int y = 9; y < VT; y++) line(y, 0, HT, 1'b1, 1'b0);
    chk("short_err_one_cycle", 32'(err_cycles), 1);
    exp_lock = 1'b0;
    frame(1'b0);
    chk("relock_not_early", 32'(lock_v0), 0);
    exp_lock = 1'b1;
    frame(1'b1);
    chk("relock", 32'(lock_v0), 1);

    // h_sync held inactive for two line periods.
    for (int y = 0; y < 5; y++) line(y, 0, HT, 1'b1, 1'b0);
    line(5, 0, HT, 1'b0, 1'b0);
    chk("pre_timeout_locked", 32'(lock_x0), 1);
    chk("pre_timeout_no_err", 32'(err_x0), 0);
    line(6, 0, HT, 1'b0, 1'b0);
    chk("timeout_sync_err", 32'(err_x0), 1);
    chk("timeout_unlock", 32'(lock_x0), 0);
    line(7, 0, HT, 1'b1, 1'b0);
    chk("no_hs_le_during_hold", 32'(len_x0), 3 * HT);
    for (int y = 8; y < VT; y++) line(y, 0, HT, 1'b1, 1'b0);
    chk("timeout_err_one_cycle", 32'(err_cycles), 2);
    exp_lock = 1'b0;
    frame(1'b0);
    chk("timeout_relock_not_early", 32'(lock_v0), 0);
    exp_lock = 1'b1;
    for (int y = 0; y < 10; y++) line(y, 0, HT, 1'b1, 1'b1);
    chk("timeout_relock", 32'(lock_v0), 1);

    // Asynchronous reset in mid-frame.
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_locked", 32'(locked), 0);
    chk("async_rst_line_len", 32'(line_len), 0);
    chk("async_rst_frame_lines", 32'(frame_lines), 0);
    @(negedge pixel_clk);
    reset_n = 1'b1;
    exp_lock = 1'b0;
    for (int y = 10; y < VT; y++) line(y, 0, HT, 1'b1, 1'b0);
    frame(1'b0);
    chk("post_rst_not_early", 32'(lock_v0), 0);
    exp_lock = 1'b1;
    frame(1'b1);
    chk("post_rst_relock", 32'(lock_v0), 1);
    chk("post_rst_frame_lines", 32'(flines_v0), VT);
    chk("total_sync_err_cycles", 32'(err_cycles), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
